// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Host-side command responder for the uart core. Unloads received bytes,
//   decodes Write ('W' addr data), Read ('R' addr) and Burst ('B' addr cnt)
//   commands against a synchronous block-RAM port, and returns every response
//   byte through the uart TX handshake.
//
// Ports
//   clk, reset            : system clock, asynchronous active-high reset
//   rx_empty, rx_data     : uart RX status / byte (byte valid cycle after unload)
//   uld_rx_data           : one-cycle unload pulse to uart
//   tx_empty              : uart transmitter idle
//   ld_tx_data, tx_data   : one-cycle load pulse and response byte to uart
//   mem_en, mem_we        : memory strobe and write enable
//   mem_addr, mem_wdata   : memory address and write data
//   mem_rdata             : memory read data, valid one cycle after a read strobe
//   busy                  : command partially received or being executed/answered
//   bad_cmd               : one-cycle pulse on an unknown opcode
//   timeout_err           : one-cycle pulse when a partial command is discarded
module uart_cmd_responder #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        rx_data,
  output logic              uld_rx_data,
  input  logic              tx_empty,
  output logic              ld_tx_data,
  output logic [7:0]        tx_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              bad_cmd,
  output logic              timeout_err
);

  localparam logic [7:0]  OP_W = 8'h57;
  localparam logic [7:0]  OP_R = 8'h52;
  localparam logic [7:0]  OP_B = 8'h42;
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_WAIT, S_UNLOAD, S_CAPTURE, S_DECODE, S_MEM_WR,
    S_MEM_RD, S_RD_LAT, S_SEND, S_SEND_GAP
  } state_t;

  state_t            r_state;
  logic [1:0]        r_idx;
  logic [7:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;   // write data for 'W', byte count for 'B'
  logic [7:0]        r_rem;    // burst bytes still to send after the current one
  logic [23:0]       r_tmo;
  logic [7:0]        r_tx;
  logic              r_uld, r_ld, r_en, r_we, r_bad, r_tmo_err;

  assign uld_rx_data = r_uld;
  assign ld_tx_data  = r_ld;
  assign tx_data     = r_tx;
  assign mem_en      = r_en;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_data;
  assign bad_cmd     = r_bad;
  assign timeout_err = r_tmo_err;
  assign busy        = !((r_state == S_WAIT) && (r_idx == 2'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_WAIT;
      r_idx     <= 2'd0;
      r_op      <= 8'h00;
      r_addr    <= '0;
      r_data    <= 8'h00;
      r_rem     <= 8'h00;
      r_tmo     <= 24'd0;
      r_tx      <= 8'h00;
      r_uld     <= 1'b0;
      r_ld      <= 1'b0;
      r_en      <= 1'b0;
      r_we      <= 1'b0;
      r_bad     <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      // All strobes are single-cycle; they default low every cycle.
      r_uld     <= 1'b0;
      r_ld      <= 1'b0;
      r_en      <= 1'b0;
      r_we      <= 1'b0;
      r_bad     <= 1'b0;
      r_tmo_err <= 1'b0;

      case (r_state)
        S_WAIT: begin
          if (!rx_empty) begin
            r_uld   <= 1'b1;
            r_state <= S_UNLOAD;
          end else if (r_idx != 2'd0) begin
            if (r_tmo == TMO_LAST) begin
              r_tmo_err <= 1'b1;
              r_idx     <= 2'd0;
              r_tmo     <= 24'd0;
            end else begin
              r_tmo <= r_tmo + 24'd1;
            end
          end
        end

        S_UNLOAD: r_state <= S_CAPTURE;

        S_CAPTURE: begin
          r_tmo <= 24'd0;
          case (r_idx)
            2'd0: begin
              r_op <= rx_data;
              // Unknown opcodes are complete after one byte.
              if (rx_data == OP_W || rx_data == OP_R || rx_data == OP_B) begin
                r_idx   <= 2'd1;
                r_state <= S_WAIT;
              end else begin
                r_state <= S_DECODE;
              end
            end
            2'd1: begin
              r_addr <= rx_data[ADDR_W-1:0];
              if (r_op == OP_R) begin
                r_state <= S_DECODE;
              end else begin
                r_idx   <= 2'd2;
                r_state <= S_WAIT;
              end
            end
            default: begin
              r_data  <= rx_data;
              r_state <= S_DECODE;
            end
          endcase
        end

        S_DECODE: begin
          case (r_op)
            OP_W: begin
              r_en    <= 1'b1;
              r_we    <= 1'b1;
              r_state <= S_MEM_WR;
            end
            OP_R: begin
              r_rem   <= 8'h00;
              r_en    <= 1'b1;
              r_state <= S_MEM_RD;
            end
            OP_B: begin
              // cnt=0 wraps to 255 remaining, i.e. 256 bytes in total.
              r_rem   <= r_data - 8'd1;
              r_en    <= 1'b1;
              r_state <= S_MEM_RD;
            end
            default: begin
              r_tx    <= 8'h3F;
              r_bad   <= 1'b1;
              r_state <= S_SEND;
            end
          endcase
        end

        S_MEM_WR: begin
          r_tx    <= 8'h4B;
          r_state <= S_SEND;
        end

        S_MEM_RD: r_state <= S_RD_LAT;

        S_RD_LAT: begin
          r_tx    <= mem_rdata;
          r_state <= S_SEND;
        end

        S_SEND: begin
          if (tx_empty) begin
            r_ld    <= 1'b1;
            r_state <= S_SEND_GAP;
          end
        end

        S_SEND_GAP: begin
          if (r_op == OP_B && r_rem != 8'h00) begin
            r_addr  <= r_addr + 1'b1;
            r_rem   <= r_rem - 8'd1;
            r_en    <= 1'b1;
            r_state <= S_MEM_RD;
          end else begin
            r_idx   <= 2'd0;
            r_state <= S_WAIT;
          end
        end

        default: r_state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       uld_rx_data;
  logic       tx_empty = 1'b1;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy, bad_cmd, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_cmd_responder #(.ADDR_W(8), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset),
    .rx_empty(rx_empty), .rx_data(rx_data), .uld_rx_data(uld_rx_data),
    .tx_empty(tx_empty), .ld_tx_data(ld_tx_data), .tx_data(tx_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .bad_cmd(bad_cmd), .timeout_err(timeout_err)
  );

  // ---------------- uart RX model ----------------
  logic [7:0] rxq[$];
  always @(posedge clk) begin
    if (uld_rx_data && rxq.size() > 0) rx_data <= rxq.pop_front();
    rx_empty <= (rxq.size() == 0);
  end

  // ---------------- uart TX model ----------------
  logic [7:0] txq[$];
  int tx_total = 0;
  int tx_timer = 0;
  always @(posedge clk) begin
    if (ld_tx_data) begin
      txq.push_back(tx_data);
      tx_total <= tx_total + 1;
      tx_empty <= 1'b0;
      tx_timer <= 20;
    end else if (tx_timer > 0) begin
      tx_timer <= tx_timer - 1;
      if (tx_timer == 1) tx_empty <= 1'b1;
    end
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- event monitor ----------------
  int we_cnt = 0, rd_cnt = 0, bad_cnt = 0, tmo_cnt = 0, viol = 0;
  logic [7:0] last_we_addr = 8'h00, last_we_data = 8'h00, last_rd_addr = 8'h00;
  logic prev_pulse = 1'b0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      we_cnt <= we_cnt + 1; last_we_addr <= mem_addr; last_we_data <= mem_wdata;
    end
    if (mem_en && !mem_we) begin
      rd_cnt <= rd_cnt + 1; last_rd_addr <= mem_addr;
    end
    if (bad_cmd) bad_cnt <= bad_cnt + 1;
    if (timeout_err) tmo_cnt <= tmo_cnt + 1;
    if ((ld_tx_data && !tx_empty) || (ld_tx_data && uld_rx_data) ||
        (prev_pulse && (ld_tx_data || uld_rx_data)) || (mem_we && !mem_en))
      viol <= viol + 1;
    prev_pulse <= ld_tx_data | uld_rx_data;
  end

  // ---------------- helpers ----------------
  task automatic push3(input int n, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
    rxq.push_back(b0);
    if (n > 1) rxq.push_back(b1);
    if (n > 2) rxq.push_back(b2);
  endtask

  // Waits until all bytes are consumed, the responder is idle and TX is idle.
  task automatic wait_done(input string name, input int max_cycles);
    int k = 0;
    while (!(rxq.size() == 0 && rx_empty && !busy && tx_empty) && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    if (k >= max_cycles) begin
      n_checks++;
      $display("FAIL %s: idle not reached within %0d cycles (busy=%b tx_empty=%b)",
               name, max_cycles, busy, tx_empty);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %02h expected %02h", name, got, exp);
    else n_pass++;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  task automatic pop_tx(output logic [7:0] b);
    if (txq.size() > 0) b = txq.pop_front();
    else b = 8'hXX;
  endtask

  task automatic check_outputs_zero(input string name);
    logic [31:0] vec;
    vec = {uld_rx_data, ld_tx_data, tx_data, mem_en, mem_we, mem_addr, mem_wdata,
           busy, bad_cmd, timeout_err};
    n_checks++;
    if (vec !== 32'h0) $display("FAIL %s: outputs %08h expected 00000000", name, vec);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("post_reset_idle");
    $display("test_reset done");
  endtask

  task automatic test_write(input logic [7:0] a, input logic [7:0] d);
    int we0, rd0;
    logic [7:0] b;
    we0 = we_cnt; rd0 = rd_cnt; txq.delete();
    push3(3, 8'h57, a, d);
    wait_done("write", 200);
    check_int("write_we_count", we_cnt - we0, 1);
    check_int("write_no_read", rd_cnt - rd0, 0);
    check_byte("write_addr", last_we_addr, a);
    check_byte("write_data", last_we_data, d);
    check_int("write_tx_count", txq.size(), 1);
    pop_tx(b);
    check_byte("write_ack", b, 8'h4B);
    check_int("write_busy", int'(busy), 0);
    $display("write %02h <= %02h done", a, d);
  endtask

  task automatic test_read(input logic [7:0] a, input logic [7:0] exp);
    int we0, rd0;
    logic [7:0] b;
    we0 = we_cnt; rd0 = rd_cnt; txq.delete();
    push3(2, 8'h52, a, 8'h00);
    wait_done("read", 200);
    check_int("read_rd_count", rd_cnt - rd0, 1);
    check_int("read_no_write", we_cnt - we0, 0);
    check_byte("read_addr", last_rd_addr, a);
    check_int("read_tx_count", txq.size(), 1);
    pop_tx(b);
    check_byte("read_data", b, exp);
    $display("read %02h -> %02h done", a, exp);
  endtask

  task automatic test_burst_wrap();
    int rd0;
    logic [7:0] b;
    test_write(8'hFE, 8'h01);
    test_write(8'hFF, 8'h02);
    test_write(8'h00, 8'h03);
    rd0 = rd_cnt; txq.delete();
    push3(3, 8'h42, 8'hFE, 8'h03);
    wait_done("burst", 500);
    check_int("burst_rd_count", rd_cnt - rd0, 3);
    check_int("burst_tx_count", txq.size(), 3);
    pop_tx(b); check_byte("burst_byte0", b, 8'h01);
    pop_tx(b); check_byte("burst_byte1", b, 8'h02);
    pop_tx(b); check_byte("burst_byte2", b, 8'h03);
    check_byte("burst_wrap_addr", last_rd_addr, 8'h00);
    $display("burst FE x3 done");
  endtask

  task automatic test_bad_opcode();
    int bad0;
    logic [7:0] b;
    bad0 = bad_cnt; txq.delete();
    push3(3, 8'h00, 8'h52, 8'h10);
    wait_done("bad_opcode", 300);
    check_int("bad_pulse_count", bad_cnt - bad0, 1);
    check_int("bad_tx_count", txq.size(), 2);
    pop_tx(b); check_byte("bad_reply", b, 8'h3F);
    pop_tx(b); check_byte("bad_then_read", b, 8'hA5);
    $display("bad opcode 00 then read done");
  endtask

  task automatic test_timeout();
    int we0, tmo0, tx0, k;
    we0 = we_cnt; tmo0 = tmo_cnt; tx0 = tx_total;
    push3(2, 8'h57, 8'h10, 8'h00);
    k = 0;
    while (!(rxq.size() == 0 && rx_empty) && k < 50) begin
      @(negedge clk); k++;
    end
    k = 0;
    while (tmo_cnt == tmo0 && k < 300) begin
      @(negedge clk); k++;
    end
    check_int("timeout_pulse_count", tmo_cnt - tmo0, 1);
    n_checks++;
    if (k < 95 || k > 110) $display("FAIL timeout_latency: got %0d cycles expected 95..110", k);
    else n_pass++;
    repeat (5) @(negedge clk);
    check_int("timeout_no_write", we_cnt - we0, 0);
    check_int("timeout_no_tx", tx_total - tx0, 0);
    check_int("timeout_busy", int'(busy), 0);
    test_read(8'h10, 8'hA5);
    $display("timeout done");
  endtask

  task automatic test_reset_mid_burst();
    int tx0, k, tx_at_reset;
    logic [7:0] b;
    tx0 = tx_total; txq.delete();
    push3(3, 8'h42, 8'h00, 8'h00);
    k = 0;
    while (tx_total - tx0 < 3 && k < 1000) begin
      @(negedge clk); k++;
    end
    check_int("midburst_started", (tx_total - tx0 >= 3) ? 1 : 0, 1);
    pop_tx(b);
    check_byte("midburst_byte0", b, 8'h03);
    // Assert away from the edge: outputs must clear asynchronously.
    #2 reset = 1'b1;
    #1 check_outputs_zero("midburst_reset_async");
    tx_at_reset = tx_total;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    check_int("midburst_no_more_tx", tx_total - tx_at_reset, 0);
    check_int("midburst_idle", int'(busy), 0);
    test_read(8'h00, 8'h03);
    $display("reset mid-burst done");
  endtask

  task automatic test_protocol();
    check_int("protocol_violations", viol, 0);
    $display("protocol check done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_write(8'h10, 8'hA5);
    test_read(8'h10, 8'hA5);
    test_burst_wrap();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_burst();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
